// File: rtl/mem_pkg.sv
// Shared types and helpers for the N-read / 1-write synchronous memory.
// Helpers work on MEM_MAX_W-bit padded words so any legal geometry can use them.
package mem_pkg;

  localparam int MEM_MAX_W = 256;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } mem_state_e;

  // Strobed bytes take new_w, the rest keep old_w.
  function automatic logic [MEM_MAX_W-1:0] byte_merge(
    input logic [MEM_MAX_W-1:0] old_w,
    input logic [MEM_MAX_W-1:0] new_w,
    input logic [MEM_MAX_W-1:0] strb,
    input int                   byte_w
  );
    logic [MEM_MAX_W-1:0] r;
    for (int b = 0; b < MEM_MAX_W; b++) begin
      r[b] = strb[b / byte_w] ? new_w[b] : old_w[b];
    end
    return r;
  endfunction

  // Even parity per byte: bit k is the XOR of byte k.
  function automatic logic [MEM_MAX_W-1:0] parity_gen(
    input logic [MEM_MAX_W-1:0] word,
    input int                   byte_w
  );
    logic [MEM_MAX_W-1:0] p;
    p = '0;
    for (int b = 0; b < MEM_MAX_W; b++) begin
      p[b / byte_w] = p[b / byte_w] ^ word[b];
    end
    return p;
  endfunction

endpackage

// File: rtl/mem_nr1w_sync_read_port.sv
// One read port: write-first bypass, range check, 1- or 2-stage pipeline, parity check.
// Parity checking is present only when MEM_PARITY_EN is defined.
module mem_read_port
  import mem_pkg::*;
#(
  parameter int p_num_entries  = 16,
  parameter int p_bit_width    = 32,
  parameter int p_byte_width   = 8,
  parameter int p_read_latency = 1,
  parameter int p_addr_width   = 4,
  parameter int p_strb_width   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rd_fire,
  input  logic [p_addr_width-1:0] rd_addr,
  input  logic [p_bit_width-1:0]  mem_word,
  input  logic [p_strb_width-1:0] mem_par,
  input  logic                    wr_fire,
  input  logic [p_addr_width-1:0] wr_addr,
  input  logic [p_bit_width-1:0]  wr_word,
  input  logic [p_strb_width-1:0] wr_par,
  output logic                    rd_valid,
  output logic [p_bit_width-1:0]  rd_data,
  output logic                    rd_err
);

  localparam logic [p_addr_width:0] NUM_ENT = (p_addr_width+1)'(p_num_entries);

  logic                    in_range;
  logic                    hit;
  logic [p_bit_width-1:0]  word_s;
  logic [p_strb_width-1:0] par_s;
  logic                    err_s;

  // wr_word is already the merged word, so a hit returns new strobed bytes and old others.
  always_comb begin
    in_range = ({1'b0, rd_addr} < NUM_ENT);
    hit      = wr_fire && (wr_addr == rd_addr);
    word_s   = hit ? wr_word : mem_word;
    par_s    = hit ? wr_par  : mem_par;
    if (!in_range) begin
      word_s = '0;
      par_s  = '0;
    end
  end

`ifdef MEM_PARITY_EN
  logic [MEM_MAX_W-1:0] word_pad;
  logic [MEM_MAX_W-1:0] par_pad;
  always_comb begin
    word_pad = '0;
    word_pad[p_bit_width-1:0] = word_s;
    par_pad = '0;
    par_pad[p_strb_width-1:0] = par_s;
    err_s = in_range && (parity_gen(word_pad, p_byte_width) != par_pad);
  end
`else
  logic unused_par;
  assign unused_par = ^{par_s, in_range};
  assign err_s = 1'b0;
`endif

  logic                   v1, e1;
  logic [p_bit_width-1:0] d1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1 <= 1'b0;
      d1 <= '0;
      e1 <= 1'b0;
    end else begin
      v1 <= rd_fire;
      if (rd_fire) begin
        d1 <= word_s;
        e1 <= err_s;
      end
    end
  end

  if (p_read_latency == 2) begin : g_lat2
    logic                   v2, e2;
    logic [p_bit_width-1:0] d2;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v2 <= 1'b0;
        d2 <= '0;
        e2 <= 1'b0;
      end else begin
        v2 <= v1;
        if (v1) begin
          d2 <= d1;
          e2 <= e1;
        end
      end
    end
    assign rd_valid = v2;
    assign rd_data  = d2;
    assign rd_err   = v2 & e2;
  end else begin : g_lat1
    assign rd_valid = v1;
    assign rd_data  = d1;
    assign rd_err   = v1 & e1;
  end

endmodule

// File: rtl/mem_nr1w_sync.sv
// N-read / 1-write synchronous memory with byte strobes and a post-reset clear sequencer.
// Define MEM_PARITY_EN to store and check per-byte even parity.
module mem_nr1w_sync
  import mem_pkg::*;
#(
  parameter int p_num_entries  = 16,
  parameter int p_bit_width    = 32,
  parameter int p_byte_width   = 8,
  parameter int p_num_rd_ports = 2,
  parameter int p_read_latency = 1,
  parameter int p_addr_width   = $clog2(p_num_entries),
  parameter int p_strb_width   = p_bit_width / p_byte_width
) (
  input  logic                                          clk,
  input  logic                                          reset,
  output logic                                          init_busy,
  input  logic                                          write_en,
  input  logic [p_addr_width-1:0]                       write_addr,
  input  logic [p_strb_width-1:0]                       write_strb,
  input  logic [p_bit_width-1:0]                        write_data,
  input  logic                                          err_inject,
  input  logic [p_num_rd_ports-1:0]                     read_en,
  input  logic [p_num_rd_ports-1:0][p_addr_width-1:0]   read_addr,
  output logic [p_num_rd_ports-1:0]                     read_valid,
  output logic [p_num_rd_ports-1:0][p_bit_width-1:0]    read_data,
  output logic [p_num_rd_ports-1:0]                     read_err
);

  localparam logic [p_addr_width:0]   NUM_ENT = (p_addr_width+1)'(p_num_entries);
  localparam logic [p_addr_width-1:0] LAST    = p_addr_width'(p_num_entries - 1);

  mem_state_e              state_q, state_d;
  logic [p_addr_width-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST) begin
          state_d = READY;
          ptr_d   = '0;
        end
      end
      default: ;
    endcase
  end

  assign init_busy = (state_q == INIT);

  logic [p_bit_width-1:0]  mem [p_num_entries];
  logic                    wr_fire;
  logic [p_bit_width-1:0]  wr_word;
  logic [p_strb_width-1:0] wr_par;
  logic [MEM_MAX_W-1:0]    old_pad, new_pad, strb_pad, merge_full;
  logic                    unused_merge_hi;

  always_comb begin
    wr_fire  = (state_q == READY) && write_en && ({1'b0, write_addr} < NUM_ENT);
    old_pad  = '0;
    new_pad  = '0;
    strb_pad = '0;
    if (wr_fire) old_pad[p_bit_width-1:0] = mem[write_addr];
    new_pad[p_bit_width-1:0]   = write_data;
    strb_pad[p_strb_width-1:0] = write_strb;
    merge_full = byte_merge(old_pad, new_pad, strb_pad, p_byte_width);
    wr_word    = merge_full[p_bit_width-1:0];
  end

  assign unused_merge_hi = ^merge_full[MEM_MAX_W-1:p_bit_width];

  // The clear sequence owns the write port until it finishes.
  always_ff @(posedge clk) begin
    if (init_busy) mem[ptr_q] <= '0;
    else if (wr_fire) mem[write_addr] <= wr_word;
  end

  logic [p_strb_width-1:0] rd_par [p_num_rd_ports];

`ifdef MEM_PARITY_EN
  logic [p_strb_width-1:0] par_mem [p_num_entries];
  logic [p_strb_width-1:0] old_par;
  logic [MEM_MAX_W-1:0]    par_full;
  logic                    unused_par_hi;

  // Unstrobed bytes keep their stored parity, including a previously injected error.
  always_comb begin
    old_par  = wr_fire ? par_mem[write_addr] : '0;
    par_full = parity_gen(merge_full, p_byte_width);
    for (int k = 0; k < p_strb_width; k++) begin
      wr_par[k] = write_strb[k] ? par_full[k] : old_par[k];
    end
    wr_par[0] = wr_par[0] ^ err_inject;
  end

  assign unused_par_hi = ^par_full[MEM_MAX_W-1:p_strb_width];

  always_ff @(posedge clk) begin
    if (init_busy) par_mem[ptr_q] <= '0;
    else if (wr_fire) par_mem[write_addr] <= wr_par;
  end

  for (genvar i = 0; i < p_num_rd_ports; i++) begin : g_rpar
    assign rd_par[i] = par_mem[read_addr[i]];
  end
`else
  logic unused_inject;
  assign unused_inject = err_inject;
  assign wr_par = '0;
  for (genvar i = 0; i < p_num_rd_ports; i++) begin : g_rpar
    assign rd_par[i] = '0;
  end
`endif

  for (genvar i = 0; i < p_num_rd_ports; i++) begin : g_rd
    mem_read_port #(
      .p_num_entries (p_num_entries),
      .p_bit_width   (p_bit_width),
      .p_byte_width  (p_byte_width),
      .p_read_latency(p_read_latency),
      .p_addr_width  (p_addr_width),
      .p_strb_width  (p_strb_width)
    ) u_port (
      .clk     (clk),
      .reset   (reset),
      .rd_fire ((state_q == READY) && read_en[i]),
      .rd_addr (read_addr[i]),
      .mem_word(mem[read_addr[i]]),
      .mem_par (rd_par[i]),
      .wr_fire (wr_fire),
      .wr_addr (write_addr),
      .wr_word (wr_word),
      .wr_par  (wr_par),
      .rd_valid(read_valid[i]),
      .rd_data (read_data[i]),
      .rd_err  (read_err[i])
    );
  end

endmodule

// File: tb/tb_mem_nr1w_sync.sv
// Directed bench: one latency-1 instance (16 entries) and one latency-2 instance (12 entries)
// driven by the same inputs; expected values are hand-computed constants.
module tb_mem_nr1w_sync;

`ifdef MEM_PARITY_EN
  localparam logic PAR = 1'b1;
`else
  localparam logic PAR = 1'b0;
`endif

  logic             clk, reset;
  logic             write_en, err_inject;
  logic [3:0]       write_addr, write_strb;
  logic [31:0]      write_data;
  logic [1:0]       read_en;
  logic [1:0][3:0]  read_addr;
  logic             busy1, busy2;
  logic [1:0]       rv1, rv2, re1, re2;
  logic [1:0][31:0] rd1, rd2;

  int total = 0;
  int bad   = 0;

  mem_nr1w_sync #(.p_num_entries(16), .p_read_latency(1)) u_dut (
    .clk(clk), .reset(reset), .init_busy(busy1),
    .write_en(write_en), .write_addr(write_addr), .write_strb(write_strb),
    .write_data(write_data), .err_inject(err_inject),
    .read_en(read_en), .read_addr(read_addr),
    .read_valid(rv1), .read_data(rd1), .read_err(re1)
  );

  mem_nr1w_sync #(.p_num_entries(12), .p_read_latency(2)) u_dut2 (
    .clk(clk), .reset(reset), .init_busy(busy2),
    .write_en(write_en), .write_addr(write_addr), .write_strb(write_strb),
    .write_data(write_data), .err_inject(err_inject),
    .read_en(read_en), .read_addr(read_addr),
    .read_valid(rv2), .read_data(rd2), .read_err(re2)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_en = 1'b0; err_inject = 1'b0; write_addr = '0; write_strb = '0;
    write_data = '0; read_en = '0; read_addr[0] = '0; read_addr[1] = '0;
  endtask

  task automatic init_wait(input logic poke);
    int n1, n2;
    n1 = 0;
    n2 = 0;
    for (int k = 1; k <= 40; k++) begin
      if (poke && k <= 10) begin
        write_en = 1'b1; write_addr = 4'd4; write_data = 32'hFFFF_FFFF; write_strb = 4'hF;
        read_en = 2'b11; read_addr[0] = 4'd4; read_addr[1] = 4'd4;
      end else begin
        idle();
      end
      step();
      if (busy1) chk("init_valid1", 64'(rv1), 64'd0);
      if (busy2) chk("init_valid2", 64'(rv2), 64'd0);
      if (n1 == 0 && !busy1) n1 = k;
      if (n2 == 0 && !busy2) n2 = k;
      if (n1 != 0 && n2 != 0) break;
    end
    idle();
    chk("init_len16", 64'(n1), 64'd16);
    chk("init_len12", 64'(n2), 64'd12);
  endtask

  // Optional write plus a read on both ports; e* expect latency-1 data, f* latency-2 data.
  task automatic rd_wr(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] ws, input logic inj,
                       input logic [3:0] a0, input logic [3:0] a1,
                       input logic [31:0] e0, input logic [31:0] e1,
                       input logic [31:0] f0, input logic [31:0] f1, input logic [1:0] ee);
    write_en = we; write_addr = wa; write_data = wd; write_strb = ws; err_inject = inj;
    read_en = 2'b11; read_addr[0] = a0; read_addr[1] = a1;
    step();
    idle();
    chk("l1_valid", 64'(rv1), 64'd3);
    chk("l1_data0", 64'(rd1[0]), 64'(e0));
    chk("l1_data1", 64'(rd1[1]), 64'(e1));
    chk("l1_err", 64'(re1), 64'(ee));
    chk("l2_wait", 64'(rv2), 64'd0);
    step();
    chk("l2_valid", 64'(rv2), 64'd3);
    chk("l2_data0", 64'(rd2[0]), 64'(f0));
    chk("l2_data1", 64'(rd2[1]), 64'(f1));
    chk("l2_err", 64'(re2), 64'(ee));
    chk("l1_idle", 64'(rv1), 64'd0);
    chk("l1_hold", 64'(rd1[0]), 64'(e0));
  endtask

  task automatic rd(input logic [3:0] a0, input logic [3:0] a1,
                    input logic [31:0] e0, input logic [31:0] e1);
    rd_wr(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, a0, a1, e0, e1, e0, e1, 2'b00);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, input logic inj);
    write_en = 1'b1; write_addr = a; write_data = d; write_strb = s; err_inject = inj;
    step();
    idle();
  endtask

  logic [31:0] vals [3];

  initial begin
    idle();
    reset = 1'b1;
    step();
    step();
    chk("rst_busy", 64'({busy1, busy2}), 64'd3);
    chk("rst_valid", 64'({rv1, rv2}), 64'd0);
    chk("rst_data", 64'(rd1[0] | rd1[1] | rd2[0] | rd2[1]), 64'd0);
    chk("rst_err", 64'({re1, re2}), 64'd0);

    // clear sequence length; writes and reads during it are ignored
    reset = 1'b0;
    init_wait(1'b1);
    for (int a = 0; a < 16; a++) rd(4'(a), 4'(15 - a), 32'd0, 32'd0);

    // byte-masked writes
    wr(4'd3, 32'hDEAD_BEEF, 4'hF, 1'b0);
    wr(4'd3, 32'h0000_AA00, 4'h2, 1'b0);
    rd(4'd3, 4'd3, 32'hDEAD_AAEF, 32'hDEAD_AAEF);

    // write-first bypass, full and partial
    rd_wr(1'b1, 4'd5, 32'h1234_5678, 4'hF, 1'b0, 4'd5, 4'd5,
          32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 2'b00);
    rd_wr(1'b1, 4'd3, 32'h0000_0011, 4'h1, 1'b0, 4'd3, 4'd5,
          32'hDEAD_AA11, 32'h1234_5678, 32'hDEAD_AA11, 32'h1234_5678, 2'b00);

    // back-to-back reads of addrs 0,1,2
    vals[0] = 32'hA0A0_A0A0; vals[1] = 32'hB1B1_B1B1; vals[2] = 32'hC2C2_C2C2;
    for (int i = 0; i < 3; i++) wr(4'(i), vals[i], 4'hF, 1'b0);
    for (int c = 0; c < 5; c++) begin
      read_en = (c < 3) ? 2'b11 : 2'b00;
      read_addr[0] = 4'(c); read_addr[1] = 4'(c);
      step();
      chk("b2b_v1", 64'(rv1), (c <= 2) ? 64'd3 : 64'd0);
      chk("b2b_d1", 64'(rd1[1]), 64'(vals[(c < 2) ? c : 2]));
      chk("b2b_v2", 64'(rv2), (c >= 1 && c <= 3) ? 64'd3 : 64'd0);
      if (c >= 1) chk("b2b_d2", 64'(rd2[0]), 64'(vals[(c - 1 < 2) ? c - 1 : 2]));
    end
    idle();

    // addr 14: in range for 16 entries, out of range for 12 (read 0, write dropped)
    rd_wr(1'b1, 4'd14, 32'h9999_9999, 4'hF, 1'b0, 4'd14, 4'd2,
          32'h9999_9999, 32'hC2C2_C2C2, 32'd0, 32'hC2C2_C2C2, 2'b00);
    rd_wr(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd14, 4'd3,
          32'h9999_9999, 32'hDEAD_AA11, 32'd0, 32'hDEAD_AA11, 2'b00);
    rd_wr(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd12, 4'd11, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00);

    // parity injection on byte 0, survives a write to byte 1, cleared by rewriting byte 0
    rd_wr(1'b1, 4'd7, 32'h0000_0055, 4'hF, 1'b1, 4'd7, 4'd6,
          32'h55, 32'd0, 32'h55, 32'd0, {1'b0, PAR});
    rd_wr(1'b1, 4'd7, 32'h0000_AA00, 4'h2, 1'b0, 4'd6, 4'd7,
          32'd0, 32'hAA55, 32'd0, 32'hAA55, {PAR, 1'b0});
    rd_wr(1'b1, 4'd7, 32'h0000_0066, 4'h1, 1'b0, 4'd7, 4'd7,
          32'hAA66, 32'hAA66, 32'hAA66, 32'hAA66, 2'b00);

    // asynchronous reset while data is valid
    read_en = 2'b11; read_addr[0] = 4'd0; read_addr[1] = 4'd1;
    step();
    idle();
    chk("pre_rst_valid", 64'(rv1), 64'd3);
    reset = 1'b1;
    #1;
    chk("async_valid", 64'({rv1, rv2}), 64'd0);
    chk("async_data", 64'(rd1[0] | rd1[1] | rd2[0] | rd2[1]), 64'd0);
    chk("async_busy", 64'({busy1, busy2}), 64'd3);
    step();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("mid_init_busy", 64'({busy1, busy2}), 64'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    init_wait(1'b0);
    rd(4'd7, 4'd3, 32'd0, 32'd0);
    rd(4'd5, 4'd0, 32'd0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
